dmem_ctrl: RTL and testbench



---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_if.sv | 23 ++
 rtl/dmem_ram_be.sv | 27 ++
 rtl/dmem_ctrl.sv | 117 +++++++++++
 tb/tb_dmem_ctrl.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared RV32 load/store size codes plus byte-strobe and load-extension helpers for dmem_ctrl.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  function automatic logic [3:0] be_from_f3(input logic [2:0] funct3, input logic [1:0] lane);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = 4'b0001 << lane;
      F3_H:    be = 4'b0011 << lane;
      F3_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] load_align(input logic [31:0] word, input logic [2:0] funct3,
                                             input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'd0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_if.sv
// Request/response channels between a load/store master (core MEM stage or interconnect) and dmem_ctrl.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_ram_be.sv
// DEPTH_WORDS x 32 single-port SRAM with byte write enables and a registered read port.
// Read is read-before-write and only updates when i_en is high, so o_rdata holds between accesses.
module dmem_ram_be #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_be[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/dmem_ctrl.sv
// RV32 sized load/store controller over a byte-enable SRAM; response one cycle after fire, held until taken.
// One-entry response buffer: req_ready drops while a response is stalled. DMEM_BOUNDS_CHECK_EN adds range faults.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic [1:0]    w_lane;
  logic          w_f3_ok;
  logic          w_misal;
  logic          w_oob;
  logic          w_err;
  logic          w_fire;
  logic          w_en;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_ram_rdata;

  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic          r_ld_ok;
  logic [2:0]    r_f3;
  logic [1:0]    r_lane;

  assign w_off  = bus.req_addr - BASE_ADDR;
  assign w_idx  = AW'(w_off >> 2);
  assign w_lane = bus.req_addr[1:0];

  // Unsigned offset: addresses below BASE_ADDR wrap high and also land out of range.
`ifdef DMEM_BOUNDS_CHECK_EN
  assign w_oob = (w_off >> (AW + 2)) != 32'd0;
`else
  assign w_oob = 1'b0;
`endif

  always_comb begin
    w_f3_ok = 1'b0;
    w_misal = 1'b0;
    case (bus.req_funct3)
      F3_B:    w_f3_ok = 1'b1;
      F3_H: begin
        w_f3_ok = 1'b1;
        w_misal = w_lane[0];
      end
      F3_W: begin
        w_f3_ok = 1'b1;
        w_misal = |w_lane;
      end
      F3_BU:   w_f3_ok = !bus.req_we;
      F3_HU: begin
        w_f3_ok = !bus.req_we;
        w_misal = w_lane[0];
      end
      default: w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_wdata = bus.req_wdata;
    case (bus.req_funct3)
      F3_B:    w_wdata = {4{bus.req_wdata[7:0]}};
      F3_H:    w_wdata = {2{bus.req_wdata[15:0]}};
      default: w_wdata = bus.req_wdata;
    endcase
  end

  assign w_err  = !w_f3_ok || w_misal || w_oob;
  assign w_fire = bus.req_valid && bus.req_ready;
  assign w_en   = w_fire && !rst;
  assign w_be   = (bus.req_we && !w_err) ? be_from_f3(bus.req_funct3, w_lane) : 4'b0000;

  dmem_ram_be #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .i_en    (w_en),
    .i_be    (w_be),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ld_ok     <= 1'b0;
      r_f3        <= 3'd0;
      r_lane      <= 2'd0;
    end else if (w_fire) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_ld_ok     <= !bus.req_we && !w_err;
      r_f3        <= bus.req_funct3;
      r_lane      <= w_lane;
    end else if (bus.rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_ld_ok     <= 1'b0;
    end
  end

  assign bus.req_ready = !r_rsp_valid || bus.rsp_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_ld_ok ? load_align(w_ram_rdata, r_f3, r_lane) : 32'd0;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, backpressure/reset sequences, then random traffic vs a byte-array model.
module tb_dmem_ctrl;
  localparam int          DEPTH = 1024;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam logic [31:0] MEMB  = 32'd4096;
  localparam logic [2:0]  T_B = 3'd0, T_H = 3'd1, T_W = 3'd2, T_BU = 3'd4, T_HU = 3'd5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_if bus();

  dmem_ctrl #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit          we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t        tv[$];
  logic [7:0]  mm [4096];
  int          total = 0;
  int          bad   = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  function automatic void add(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    tv.push_back('{we, f3, addr, wdata, exp_rd, exp_err});
  endfunction

  // Reference: size from the code, legality and alignment by arithmetic, memory as a flat byte array.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] rd, output logic e);
    int          nbytes;
    int          a;
    logic [31:0] off;
    logic [31:0] v;
    rd = 32'd0;
    e  = 1'b0;
    off = addr - BASE;
    case (f3)
      3'd0, 3'd4: nbytes = 1;
      3'd1, 3'd5: nbytes = 2;
      3'd2:       nbytes = 4;
      default:    nbytes = 0;
    endcase
    if (nbytes == 0 || (we && f3 >= 3'd4)) e = 1'b1;
    else if ((addr % nbytes) != 0) e = 1'b1;
`ifdef DMEM_BOUNDS_CHECK_EN
    if (off >= 4 * DEPTH) e = 1'b1;
`endif
    if (e) return;
    a = int'(off % MEMB);
    if (we) begin
      for (int k = 0; k < nbytes; k++) mm[a + k] = wdata[8*k +: 8];
    end else begin
      v = 32'd0;
      for (int k = 0; k < nbytes; k++) v = v | (32'(mm[a + k]) << (8 * k));
      if (f3 == 3'd0)      rd = (v[7]  ? 32'hFFFF_FF00 : 32'd0) | v;
      else if (f3 == 3'd1) rd = (v[15] ? 32'hFFFF_0000 : 32'd0) | v;
      else                 rd = v;
    end
  endfunction

  task automatic xact(input bit we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input int stall, output logic [31:0] rd, output logic e);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.rsp_ready  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = (stall == 0);
    chk("rsp_valid_lat", 32'(bus.rsp_valid), 32'd1);
    rd = bus.rsp_rdata;
    e  = bus.rsp_err;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_rdata_hold", bus.rsp_rdata, rd);
      chk("bp_err_hold", 32'(bus.rsp_err), 32'(e));
    end
    bus.rsp_ready = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] mrd;
    logic        e;
    logic        me;
    logic [2:0]  f3;
    logic [31:0] addr;
    bit          we;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;

    add(1, T_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
    add(0, T_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    add(1, T_B,  32'h13, 32'h80,       32'h0,        1'b0);
    add(0, T_B,  32'h13, 32'h0,        32'hFFFFFF80, 1'b0);
    add(0, T_BU, 32'h13, 32'h0,        32'h00000080, 1'b0);
    add(0, T_W,  32'h10, 32'h0,        32'h80ADBEEF, 1'b0);
    add(1, T_W,  32'h20, 32'h12345678, 32'h0,        1'b0);
    add(1, T_H,  32'h22, 32'h8001,     32'h0,        1'b0);
    add(0, T_H,  32'h22, 32'h0,        32'hFFFF8001, 1'b0);
    add(0, T_HU, 32'h22, 32'h0,        32'h00008001, 1'b0);
    add(0, T_W,  32'h20, 32'h0,        32'h80015678, 1'b0);
    add(0, T_W,  32'h11, 32'h0,        32'h0,        1'b1);
    add(1, T_H,  32'h23, 32'hFFFFFFFF, 32'h0,        1'b1);
    add(0, 3'd3, 32'h20, 32'h0,        32'h0,        1'b1);
    add(1, 3'd3, 32'h20, 32'hFFFFFFFF, 32'h0,        1'b1);
    add(1, 3'd4, 32'h20, 32'hFFFFFFFF, 32'h0,        1'b1);
    add(1, T_W,  32'h22, 32'hFFFFFFFF, 32'h0,        1'b1);
    add(0, 3'd6, 32'h20, 32'h0,        32'h0,        1'b1);
    add(0, 3'd7, 32'h20, 32'h0,        32'h0,        1'b1);
    add(0, T_W,  32'h20, 32'h0,        32'h80015678, 1'b0);
    add(0, T_H,  32'h21, 32'h0,        32'h0,        1'b1);
    add(0, T_HU, 32'h20, 32'h0,        32'h00005678, 1'b0);
    add(0, T_B,  32'h21, 32'h0,        32'h00000056, 1'b0);
    add(0, T_H,  32'h20, 32'h0,        32'h00005678, 1'b0);
    add(0, T_B,  32'h23, 32'h0,        32'hFFFFFF80, 1'b0);
    add(0, T_BU, 32'h22, 32'h0,        32'h00000001, 1'b0);
    add(1, T_W,  32'h0,  32'hCAFEF00D, 32'h0,        1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    add(1, T_W,  32'h1000, 32'h11111111, 32'h0,        1'b1);
    add(0, T_W,  32'h0,    32'h0,        32'hCAFEF00D, 1'b0);
    add(0, T_W,  32'h1010, 32'h0,        32'h0,        1'b1);
`else
    add(1, T_W,  32'h1000, 32'h11111111, 32'h0,        1'b0);
    add(0, T_W,  32'h0,    32'h0,        32'h11111111, 1'b0);
    add(0, T_W,  32'h1010, 32'h0,        32'h80ADBEEF, 1'b0);
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata,      32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(bus.req_ready), 32'd1);

    foreach (tv[i]) begin
      xact(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, 0, rd, e);
      model(tv[i].we, tv[i].f3, tv[i].addr, tv[i].wdata, mrd, me);
      chk($sformatf("vec%0d_rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].exp_err));
    end

    // Load held for 3 cycles; a store offered meanwhile is refused, then withdrawn.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = T_W; bus.req_addr = 32'h20; bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    bus.req_we = 1'b1; bus.req_wdata = 32'hBAD0BAD0;
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      chk("hold_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("hold_rsp_rdata", bus.rsp_rdata, 32'h80015678);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("consume_drop_valid", 32'(bus.rsp_valid), 32'd0);
    xact(0, T_W, 32'h20, 32'h0, 0, rd, e);
    chk("hold_store_not_committed", rd, 32'h80015678);

    // Reset discards a pending response and drops a store firing on a reset edge.
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_funct3 = T_W; bus.req_addr = 32'h10; bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    chk("rst_pending_valid", 32'(bus.rsp_valid), 32'd1);
    rst = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_funct3 = T_W; bus.req_addr = 32'h20; bus.req_wdata = 32'h55555555;
    @(negedge clk);
    chk("rst_discard_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_discard_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    chk("rst_store_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("rst_store_rdata", bus.rsp_rdata, 32'd0);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    xact(0, T_W, 32'h20, 32'h0, 0, rd, e);
    chk("rst_store_suppressed", rd, 32'h80015678);

    for (int w = 0; w < 16; w++) begin
      logic [31:0] d;
      d = $urandom;
      xact(1, T_W, 32'(w * 4), d, 0, rd, e);
      model(1, T_W, 32'(w * 4), d, mrd, me);
      chk("init_err", 32'(e), 32'd0);
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] d;
      int          stall;
      we = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom_range(0, 7));
      else                          f3 = we ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 5));
      addr = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 7) == 0) addr = addr + 32'h1000 * 32'($urandom_range(1, 3));
      d = $urandom;
      stall = $urandom_range(0, 2);
      xact(we, f3, addr, d, stall, rd, e);
      model(we, f3, addr, d, mrd, me);
      chk($sformatf("rnd%0d_rdata", i), rd, mrd);
      chk($sformatf("rnd%0d_err", i), 32'(e), 32'(me));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
